if_prefetch_unit: RTL and testbench
===================================

// Module: if_prefetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage with a decoupled prefetch buffer.
//  Issues in-order word fetches to instruction memory and tracks outstanding requests.
//  Buffers returned words, with their PCs, for decode under a valid/ready handshake.
//  Takes redirects from the downstream PC controller (branch/jump/jr) and detects halt.
// PARAMETERS
//  ADDR_W     32            PC / memory address width (bits)
//  DATA_W     32            instruction word width (bits)
//  DEPTH      4             prefetch FIFO entries; power of 2, >=2; also max in flight
//  RESET_PC   'h0           PC fetched first after reset
//  HALT_INST  32'h0000000c  syscall encoding that halts fetch
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  imem_req     out  1       fetch request valid
//  imem_addr    out  ADDR_W  fetch address, word aligned
//  imem_ready   in   1       memory accepts request this cycle (req & ready = issue)
//  imem_rvalid  in   1       read data valid; responses return in issue order
//  imem_rdata   in   DATA_W  instruction word
//  redirect     in   1       flush and restart fetch at redirect_pc
//  redirect_pc  in   ADDR_W  new fetch PC; bits [1:0] are forced to 0
//  out_valid    out  1       instruction available to decode
//  out_ready    in   1       decode accepts (valid & ready = dequeue)
//  out_inst     out  DATA_W  head instruction
//  out_pc       out  ADDR_W  PC of head instruction
//  out_pc4      out  ADDR_W  out_pc + 4, modulo 2^ADDR_W
//  halted       out  1       sticky halt flag
// BEHAVIOUR
//  - Reset (async, any time): fetch_pc=RESET_PC; FIFO empty; inflight=0; drop=0;
//    state=FETCH. All outputs 0 except imem_addr=RESET_PC.
//  - FSM FETCH->HALTED: on dequeue of HALT_INST. HALTED is left only via rst.
//  - Issue: imem_req = FETCH & !redirect & (inflight + fifo_count < DEPTH).
//    On issue: fetch_pc += 4, with wrap-around at 2^ADDR_W.
//  - Response with drop>0: discarded, drop-1. Otherwise written to FIFO with its PC.
//    Credit rule guarantees no overflow; an overflow is an assertion failure.
//  - out_valid rises the cycle after the accepted rvalid (registered FIFO, no bypass).
//  - The PC is kept in a companion queue pushed on issue; the response pairs with its head.
//  - Simultaneous issue and response in one cycle: inflight is unchanged.
//  - Redirect (highest priority, one cycle):
//    - fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00}; FIFO flushed.
//    - drop <= inflight minus any response arriving in the same cycle.
//    - No issue in the redirect cycle; a dequeue in that cycle still completes.
//  - No branch delay slot: instructions after a taken branch are removed by redirect only.
//  - Halt:
//    - Dequeue of HALT_INST sets halted the next cycle; the same cycle stops imem_req.
//    - out_valid stays 0 from that point on; remaining responses are discarded.
//    - Halt and redirect in the same cycle: halt wins, redirect is ignored.
// CONFIGURATION
//  IF_JUMP_PREDECODE_EN defined:
//    - A non-dropped response with opcode 6'h02/6'h03 (J/JAL) at PC p is enqueued.
//    - In the same cycle it acts as an internal redirect to
//      {(p+4)[ADDR_W-1:28], inst[25:0], 2'b00}; younger in-flight responses are dropped.
//    - An external redirect in the same cycle overrides it.
//  IF_JUMP_PREDECODE_EN undefined: no predecode; jumps are handled by external redirect only.
// STRUCTURE
//  if_pkg:
//    - opcode constants OP_J/OP_JAL and default HALT_INST
//    - typedef fetch_entry_t {pc, inst}
//    - FSM enum {FETCH, HALTED}
//  Sub-module if_fetch_fifo:
//    - parametrised DEPTH x fetch_entry_t, async reset
//    - push/pop/flush; count output; full/empty flags
// TESTING
//  1 Stream: rst 0->1->0, imem_ready=1, rvalid 1 cycle after issue, out_ready=1
//    -> out_pc 0,4,8,... one per cycle; out_pc4 = out_pc + 4.
//  2 Backpressure: out_ready=0, DEPTH=4 -> exactly 4 issues (0x0-0xC); then
//    imem_req=0 with imem_addr=0x10 until the first dequeue.
//  3 Redirect: 2 requests in flight, redirect_pc=0x103 -> both responses dropped;
//    next imem_addr=0x100; first out_pc=0x100.
//  4 Halt: word 0x0000000c at 0x8 dequeued -> imem_req=0 the same cycle; halted=1 next
//    cycle; out_valid=0 thereafter, including after a redirect, until rst.
//  5 Async reset mid-burst with 3 in flight -> outputs clear without a clock edge;
//    late rvalids ignored; refetch starts at RESET_PC.
//  6 IF_JUMP_PREDECODE_EN: inst 0x08000040 at 0x4 -> next imem_addr=0x100; J is delivered;
//    the word fetched from 0x8 is dropped.

Source files
------------

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: opcodes, halt encoding,
// fetch-entry layout and FSM state encodings.
package if_pkg;

  localparam logic [5:0]  OP_J              = 6'h02;
  localparam logic [5:0]  OP_JAL            = 6'h03;
  localparam logic [31:0] DEFAULT_HALT_INST = 32'h0000_000c;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } if_state_e;

  // Plain constants mirror the enum so state flops stay as raw logic vectors
  localparam logic [0:0] ST_FETCH  = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/if_fetch_fifo.sv
// Registered DEPTH-entry FIFO with push/pop/flush, used both for fetched words
// and as the companion queue of outstanding fetch PCs.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_L);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is allowed only when the head leaves in the same cycle
  assign do_push = push & (~full | pop) & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with decoupled prefetch buffer, redirect and halt.
// Optional J/JAL predecode redirect is enabled by defining IF_JUMP_PREDECODE_EN.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_INST = DATA_W'(DEFAULT_HALT_INST)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc4,
  output logic              halted
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  typedef logic [ADDR_W-1:0] pc_t;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  entry_t            fifo_wdata, fifo_head;

  logic              pcq_full, pcq_empty;
  logic [CW-1:0]     inflight;
  pc_t               rsp_pc;

  logic              in_fetch, rsp, dropping, deq, halt_deq, redirect_eff;
  logic              issue, keep, jump_hit;
  logic [ADDR_W-1:0] jump_target;
  logic [CW:0]       credit_used;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign in_fetch     = (state_q == ST_FETCH);
  assign out_valid    = in_fetch & ~fifo_empty;
  assign deq          = out_valid & out_ready;
  assign halt_deq     = deq & (fifo_head.inst == HALT_INST);
  // Halt outranks redirect; once halted, redirects are ignored entirely
  assign redirect_eff = redirect & in_fetch & ~halt_deq;

  // Buffered words plus outstanding requests never exceed the FIFO capacity
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign imem_req    = ~rst & in_fetch & ~redirect & ~halt_deq & (credit_used < DEPTH_L);
  assign imem_addr   = fetch_pc_q;
  assign issue       = imem_req & imem_ready;

  // Responses with nothing outstanding are stray and ignored
  assign rsp      = imem_rvalid & ~pcq_empty;
  assign dropping = (drop_q != '0);
  assign keep     = rsp & ~dropping & in_fetch & ~redirect_eff & ~halt_deq;

  assign fifo_push       = keep;
  assign fifo_pop        = deq;
  assign fifo_flush      = redirect_eff;
  assign fifo_wdata.pc   = rsp_pc;
  assign fifo_wdata.inst = imem_rdata;

`ifdef IF_JUMP_PREDECODE_EN
  logic [ADDR_W-1:0] rsp_pc4;
  assign rsp_pc4     = rsp_pc + ADDR_W'(4);
  assign jump_hit    = keep & ((imem_rdata[31:26] == OP_J) | (imem_rdata[31:26] == OP_JAL));
  assign jump_target = {rsp_pc4[ADDR_W-1:28], imem_rdata[25:0], 2'b00};
`else
  assign jump_hit    = 1'b0;
  assign jump_target = '0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = issue ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
    drop_d     = drop_q - CW'(rsp & dropping);
    if (halt_deq) begin
      state_d = ST_HALTED;
    end
    // Every request still outstanding after this cycle belongs to the abandoned path
    if (redirect_eff) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      drop_d     = inflight - CW'(rsp);
    end else if (jump_hit) begin
      fetch_pc_d = jump_target;
      drop_d     = inflight + CW'(issue) - CW'(1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  if_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue-ordered PCs; its occupancy is the number of requests in flight
  if_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (pc_t)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (fetch_pc_q),
    .pop       (rsp),
    .flush     (1'b0),
    .pop_data  (rsp_pc),
    .count     (inflight),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  assign out_inst = out_valid ? fifo_head.inst : '0;
  assign out_pc   = out_valid ? fifo_head.pc : '0;
  assign out_pc4  = out_valid ? fifo_head.pc + ADDR_W'(4) : '0;
  assign halted   = (state_q == ST_HALTED);

  a_no_fifo_overflow : assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !fifo_pop));
  a_no_pcq_overflow : assert property (@(posedge clk) disable iff (rst)
    !(issue && pcq_full));

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: stream, backpressure, redirect, halt,
// async reset and (with IF_JUMP_PREDECODE_EN) jump predecode.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic        mem_en = 1'b0;
  logic        mem_flush = 1'b0;
  logic        halt_mode = 1'b0;
  logic        jump_mode = 1'b0;
  logic [31:0] pend[$];
  int          issue_count = 0;
  logic [31:0] last_issue = '0;

  if_prefetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_pc4     (out_pc4),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as seen by the bench
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (halt_mode && a == 32'h8) return 32'h0000_000c;
    if (jump_mode && a == 32'h4) return 32'h0800_0040;
    return 32'h2000_0000 | a;
  endfunction

  // Memory model: records issues at the clock edge and answers one cycle later in order
  always @(posedge clk) begin
    if (mem_flush) begin
      pend.delete();
    end else begin
      if (imem_rvalid && pend.size() > 0) void'(pend.pop_front());
      if (imem_req && imem_ready) begin
        pend.push_back(imem_addr);
        issue_count++;
        last_issue = imem_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_en && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(pend[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ready, input logic oready, input logic men);
    imem_ready = ready;
    out_ready  = oready;
    mem_en     = men;
  endtask

  task automatic doReset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt_mode   = 1'b0;
    jump_mode   = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    mem_flush   = 1'b1;
    repeat (2) stepCycle();
    checkOutput("reset_req", imem_req, 0);
    checkOutput("reset_addr", imem_addr, 0);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_halted", halted, 0);
    checkOutput("reset_pc4", out_pc4, 0);
    mem_flush = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int budget);
    for (int i = 0; i < budget && !out_valid; i++) stepCycle();
    checkOutput(tag, out_valid, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [31:0] got_pc [4];
    logic [31:0] got_inst [4];
    int n;

    $display("[TB] starting if_prefetch_unit bench");

    // Stream: one instruction per cycle in PC order
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitValid("t1_first_valid", 10);
    for (int k = 0; k < 6; k++) begin
      checkOutput("t1_valid", out_valid, 1);
      checkOutput("t1_pc", out_pc, 4 * k);
      checkOutput("t1_pc4", out_pc4, 4 * k + 4);
      checkOutput("t1_inst", out_inst, 32'h2000_0000 | (4 * k));
      stepCycle();
    end

    // Backpressure: credits stop issue after DEPTH requests
    doReset();
    base = issue_count;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (12) stepCycle();
    checkOutput("t2_issues", issue_count - base, 4);
    checkOutput("t2_last_issue", last_issue, 32'hC);
    checkOutput("t2_req_off", imem_req, 0);
    checkOutput("t2_addr_hold", imem_addr, 32'h10);
    checkOutput("t2_head_pc", out_pc, 0);
    out_ready = 1'b1;
    #1;
    checkOutput("t2_req_deq_cycle", imem_req, 0);
    stepCycle();
    out_ready = 1'b0;
    #1;
    checkOutput("t2_req_resume", imem_req, 1);
    checkOutput("t2_addr_resume", imem_addr, 32'h10);
    checkOutput("t2_next_pc", out_pc, 4);

    // Redirect with two requests outstanding
    doReset();
    base = issue_count;
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10 && (issue_count - base) < 2; i++) stepCycle();
    checkOutput("t3_inflight", issue_count - base, 2);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    #1;
    checkOutput("t3_req_blocked", imem_req, 0);
    stepCycle();
    redirect = 1'b0;
    mem_en   = 1'b1;
    #1;
    checkOutput("t3_addr", imem_addr, 32'h100);
    checkOutput("t3_req", imem_req, 1);
    waitValid("t3_valid", 12);
    checkOutput("t3_first_pc", out_pc, 32'h100);
    checkOutput("t3_first_inst", out_inst, 32'h2000_0100);

    // Halt on dequeue of the syscall word at 0x8
    doReset();
    halt_mode = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !(out_valid && out_pc == 32'h8); i++) stepCycle();
    checkOutput("t4_head_pc", out_pc, 32'h8);
    checkOutput("t4_head_inst", out_inst, 32'hC);
    checkOutput("t4_req_stop", imem_req, 0);
    checkOutput("t4_halted_pre", halted, 0);
    stepCycle();
    checkOutput("t4_halted", halted, 1);
    checkOutput("t4_valid_off", out_valid, 0);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    stepCycle();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("t4_valid_after", out_valid, 0);
      checkOutput("t4_req_after", imem_req, 0);
      checkOutput("t4_halted_after", halted, 1);
    end

    // Asynchronous reset with three requests in flight
    doReset();
    base = issue_count;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && (issue_count - base) < 3; i++) stepCycle();
    checkOutput("t5_inflight", issue_count - base, 3);
    checkOutput("t5_addr_pre", imem_addr, 32'hC);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_async_req", imem_req, 0);
    checkOutput("t5_async_addr", imem_addr, 0);
    checkOutput("t5_async_valid", out_valid, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("t5_stale_ignored", out_valid, 0);
    end
    checkOutput("t5_addr_restart", imem_addr, 0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitValid("t5_refetch_valid", 10);
    checkOutput("t5_refetch_pc", out_pc, 0);
    checkOutput("t5_refetch_inst", out_inst, 32'h2000_0000);

`ifdef IF_JUMP_PREDECODE_EN
    // Predecoded J at 0x4 redirects to 0x100 and drops the word from 0x8
    doReset();
    jump_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got_pc[i]   = 32'hFFFF_FFFF;
      got_inst[i] = 32'hFFFF_FFFF;
    end
    n = 0;
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20 && n < 4; i++) begin
      stepCycle();
      if (out_valid) begin
        if (out_pc == 32'h4) checkOutput("t6_addr_after_j", imem_addr, 32'h100);
        got_pc[n]   = out_pc;
        got_inst[n] = out_inst;
        n++;
      end
    end
    checkOutput("t6_pc0", got_pc[0], 32'h0);
    checkOutput("t6_pc1", got_pc[1], 32'h4);
    checkOutput("t6_inst1", got_inst[1], 32'h0800_0040);
    checkOutput("t6_pc2", got_pc[2], 32'h100);
    checkOutput("t6_pc3", got_pc[3], 32'h104);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
